// File: rtl/row_scan_if.sv
// row_scan_if: control inputs and row-select outputs of the LED-matrix row scanner.
interface row_scan_if #(parameter int N = 3);
  logic ena;
  logic mode;
  logic [N-1:0] manual_addr;
  logic [2**N-1:0] out;
  logic [N-1:0] addr;
  logic row_strobe;
  logic frame_done;
  modport master (output ena, mode, manual_addr, input out, addr, row_strobe, frame_done);
  modport slave (input ena, mode, manual_addr, output out, addr, row_strobe, frame_done);
endinterface

// File: rtl/row_scan_decoder.sv
// row_scan_decoder: registered one-hot row scanner with programmable dwell, blanking gaps and manual addressing.
module row_scan_decoder #(
  parameter int N = 3,
  parameter int PRESCALE = 4,
  parameter int BLANK = 1
) (
  input logic clk,
  input logic rst,
  row_scan_if.slave bus
);
  localparam int R = 2**N;
  localparam int MX = PRESCALE > BLANK ? PRESCALE : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] PL = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK > 0 ? BLANK - 1 : 0);
  typedef enum logic [1:0] {IDLE, BLNK, DRIVE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] addr_q, addr_d, nxt;
  logic [R-1:0] out_q, out_d;
  logic strobe_q, strobe_d, done_q, done_d, last;
  always_comb begin
    nxt = bus.mode ? bus.manual_addr : addr_q + 1'b1;
    last = cnt_q == '0;
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    out_d = out_q;
    strobe_d = 1'b0;
    done_d = 1'b0;
    if (!bus.ena) begin
      state_d = IDLE;
      cnt_d = '0;
      out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK > 0 ? BLNK : DRIVE;
          cnt_d = BLANK > 0 ? BL : PL;
          out_d = BLANK > 0 ? '0 : R'(1) << addr_q;
          strobe_d = BLANK == 0;
        end
        BLNK: begin
          state_d = last ? DRIVE : BLNK;
          cnt_d = last ? PL : cnt_q - 1'b1;
          out_d = last ? R'(1) << addr_q : '0;
          strobe_d = last;
        end
        DRIVE: begin
          cnt_d = cnt_q - 1'b1;
          // Row boundary: the next address is latched here, so mid-row input changes wait
          if (last) begin
            addr_d = nxt;
            done_d = !bus.mode && (&addr_q);
            state_d = BLANK > 0 ? BLNK : DRIVE;
            cnt_d = BLANK > 0 ? BL : PL;
            out_d = BLANK > 0 ? '0 : R'(1) << nxt;
            strobe_d = BLANK == 0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      out_q <= '0;
      strobe_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      out_q <= out_d;
      strobe_q <= strobe_d;
      done_q <= done_d;
    end
  end
  assign bus.out = out_q;
  assign bus.addr = addr_q;
  assign bus.row_strobe = strobe_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_row_scan_decoder.sv
// tb_row_scan_decoder: directed checks of two scanner configurations (N=3/P=4/B=1 and N=2/P=1/B=0).
module tb_row_scan_decoder;
  logic clk, rst;
  int n_cmp, n_bad;
  row_scan_if #(.N(3)) bus3 ();
  row_scan_if #(.N(2)) bus2 ();
  row_scan_decoder #(.N(3), .PRESCALE(4), .BLANK(1)) dut (.clk(clk), .rst(rst), .bus(bus3));
  row_scan_decoder #(.N(2), .PRESCALE(1), .BLANK(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic exp3(input string tag, input logic [7:0] o, input logic [2:0] a, input logic s, input logic d);
    chk(tag, {19'd0, bus3.out, bus3.addr, bus3.row_strobe, bus3.frame_done}, {19'd0, o, a, s, d});
  endtask
  always @(negedge clk) begin
    chk("onehot3", 32'($onehot0(bus3.out)), 32'd1);
    chk("onehot2", 32'($onehot0(bus2.out)), 32'd1);
  end
  logic [7:0] mo [1:15];
  logic [2:0] ma [1:15];
  logic ms [1:15];
  int j, r, p;
  initial begin
    n_cmp = 0;
    n_bad = 0;
    mo = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
    ma = '{3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    ms = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b0;
    bus3.ena = 1'b0; bus3.mode = 1'b0; bus3.manual_addr = '0;
    bus2.ena = 1'b0; bus2.mode = 1'b0; bus2.manual_addr = '0;
    repeat (3) @(negedge clk);
    exp3("in_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("in_reset2", {bus2.out, bus2.addr, bus2.row_strobe, bus2.frame_done}, 0);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp3("idle", 8'h00, 3'd0, 1'b0, 1'b0);
      chk("idle2", {bus2.out, bus2.addr, bus2.row_strobe, bus2.frame_done}, 0);
    end
    bus3.ena = 1'b1;
    // Edge 1 enters the blank slot; from edge 2 each row is 4 drive + 1 blank cycles
    for (int k = 1; k <= 98; k++) begin
      @(negedge clk);
      if (k == 1) exp3("auto_first_blank", 8'h00, 3'd0, 1'b0, 1'b0);
      else begin
        j = k - 2; r = j / 5; p = j % 5;
        if (p < 4) exp3("auto_drive", 8'(1) << (r % 8), 3'(r % 8), p == 0, 1'b0);
        else exp3("auto_blank", 8'h00, 3'((r + 1) % 8), 1'b0, (r % 8) == 7);
      end
    end
    bus3.ena = 1'b0;
    @(negedge clk);
    exp3("gate_off", 8'h00, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    exp3("gate_hold", 8'h00, 3'd3, 1'b0, 1'b0);
    bus3.ena = 1'b1;
    @(negedge clk);
    exp3("reen_blank", 8'h00, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    exp3("reen_drive", 8'h08, 3'd3, 1'b1, 1'b0);
    bus3.mode = 1'b1;
    bus3.manual_addr = 3'd5;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      exp3("manual", mo[t], ma[t], ms[t], 1'b0);
      if (t == 5) bus3.manual_addr = 3'd2;
    end
    bus3.mode = 1'b0;
    repeat (21) @(negedge clk);
    exp3("pre_rst", 8'h40, 3'd6, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 exp3("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    exp3("rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    exp3("restart_blank", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    exp3("restart_drive", 8'h01, 3'd0, 1'b1, 1'b0);
    bus2.ena = 1'b1;
    // Zero blanking: a new row on every edge, strobe always high, wrap every 4 cycles
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("noblank", {bus2.out, bus2.addr, bus2.row_strobe, bus2.frame_done},
          {4'(1) << ((k - 1) % 4), 2'((k - 1) % 4), 1'b1, k >= 5 && (k - 1) % 4 == 0});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
